full_event_queue: RTL and testbench
===================================

FULL_EVENT_QUEUE -- requirements
Module: full_event_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of FIFO entries (power of two, 2..16).
REQ-002 Parameter DW, default 16, event record width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 sig_in  input  1  volume-full level from the upstream load/store volume stage.
REQ-006 evt_valid  output  1  head record available.
REQ-007 evt_ready  input  1  consumer accepts head record.
REQ-008 evt_data  output  DW  head record.
REQ-009 evt_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-010 overflow  output  1  sticky flag: at least one event dropped.
REQ-011 drop_cnt  output  8  dropped-event count, saturating at 255.
REQ-012 clr_ovf  input  1  synchronous clear of overflow and drop_cnt.

Function
REQ-013 The block SHALL register sig_in into sig_q each cycle and detect rise = sig_in & ~sig_q.
REQ-014 A rise sampled at edge k SHALL push one record at edge k, with evt_valid high from edge k onward (latency 1 cycle from sig_in rising).
REQ-015 A held-high sig_in SHALL produce exactly one event; a 1-cycle sig_in pulse SHALL produce exactly one event.
REQ-016 A pop SHALL occur at an edge where evt_valid=1 and evt_ready=1; evt_ready with evt_valid=0 SHALL have no effect.
REQ-017 evt_valid SHALL equal (evt_level != 0); evt_data SHALL be the oldest record, and SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-018 Simultaneous push and pop SHALL be accepted in any occupancy, including full (evt_level unchanged) and empty (push only, since no pop).
REQ-019 A push while full without a pop SHALL drop the record, set overflow, and increment drop_cnt (saturating at 255, no wrap).
REQ-020 clr_ovf=1 SHALL clear overflow and drop_cnt next edge; a drop at the same edge SHALL win (overflow=1, drop_cnt=1).
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; evt_level SHALL range 0..DEPTH.
REQ-022 Sequence counter seq (DW bits) SHALL increment on every detected rise, including dropped ones, wrapping 2^DW-1 -> 0.

Reset
REQ-023 On rst=0, asynchronously: pointers=0, evt_level=0, evt_valid=0, evt_data=0, overflow=0, drop_cnt=0, seq=0, timestamp=0, sig_q=1.
REQ-024 sig_q resetting to 1 SHALL suppress an event if sig_in is already high at reset release; the first event requires sig_in to be seen low and then high.
REQ-025 Reset asserted mid-operation SHALL discard all queued records; no partial pop SHALL occur.

Configuration
REQ-026 Macro FEQ_TIMESTAMP_EN: when defined, a free-running DW-bit timestamp counter (reset 0, +1 per cycle, wrapping) SHALL exist, and each record SHALL be the timestamp value held before edge k.
REQ-027 When FEQ_TIMESTAMP_EN is undefined, the timestamp counter SHALL be absent and each record SHALL be the seq value before increment (first event = 0).

Verification
REQ-028 Reset release with sig_in=1 held for 10 cycles -> evt_valid stays 0 and evt_level=0.
REQ-029 sig_in 0->1 at cycle 5 after reset, evt_ready=0 -> evt_valid=1 from cycle 6, evt_level=1, evt_data=0 (macro off) or 5 (macro on).
REQ-030 Six rises with evt_ready=0, DEPTH=4 -> evt_level=4, overflow=1, drop_cnt=2; then drain 4 -> records seq 0,1,2,3 in order, evt_valid=0.
REQ-031 FIFO full with a rise and pop in the same cycle -> evt_level stays 4, no drop, new record enqueued last.
REQ-032 clr_ovf coincident with a drop -> overflow=1, drop_cnt=1; 300 drops without clear -> drop_cnt=255.
REQ-033 rst pulsed low with 3 queued records -> evt_level=0 and evt_valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/full_event_queue.sv
// Rising-edge event capture of the volume-full level into a small FIFO with overflow accounting.
// Optional macro FEQ_TIMESTAMP_EN: records carry a free-running timestamp instead of the sequence number.
module full_event_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_in,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [DW-1:0] evt_data,
    output logic [LW-1:0] evt_level,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    input  logic          clr_ovf
);

    logic          sig_q, sig_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [DW-1:0] seq_q, seq_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    logic          rise, pop, push, drop, full;
    logic [DW-1:0] record;

`ifdef FEQ_TIMESTAMP_EN
    logic [DW-1:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q + DW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_q <= '0;
        else      ts_q <= ts_d;
    end

    assign record = ts_q;
`else
    assign record = seq_q;
`endif

    always_comb begin
        evt_valid = (level_q != '0);
        full      = (level_q == LW'(DEPTH));
        rise      = sig_in & ~sig_q;
        pop       = evt_valid & evt_ready;
        // A pop frees a slot this edge, so a full queue still accepts the push.
        push      = rise & (~full | pop);
        drop      = rise & full & ~pop;

        sig_d    = sig_in;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        seq_d    = rise ? seq_q + DW'(1) : seq_q;

        level_d = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = record;

        // A drop at the same edge as a clear takes priority.
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf)                  drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
            seq_q      <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sig_q      <= sig_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            seq_q      <= seq_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign evt_level = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_full_event_queue.sv
// Bench for full_event_queue: table-driven vectors plus a record scoreboard and corner-case sequences.
module tb_full_event_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          sig_in;
    logic          evt_valid;
    logic          evt_ready;
    logic [DW-1:0] evt_data;
    logic [LW-1:0] evt_level;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          clr_ovf;

    full_event_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_level (evt_level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    // Reference cycle counter for the timestamp build.
    logic [DW-1:0] tb_ts;
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_ts <= '0;
        else      tb_ts <= tb_ts + 16'd1;
    end

    typedef struct {
        logic s, r, c;
        logic v;
        int   lvl;
        logic ovf;
        int   drp;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] exp_q[$];
    logic          sig_m;
    logic [DW-1:0] seq_m;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic s, r, c, v, input int lvl, input logic ovf, input int drp);
        vec_t e;
        e.s = s; e.r = r; e.c = c; e.v = v; e.lvl = lvl; e.ovf = ovf; e.drp = drp;
        vecs.push_back(e);
    endtask

    // Drive one cycle, update the scoreboard, then check the head record after the edge.
    task automatic step(input logic s, input logic r, input logic c);
        logic          rise, pop;
        logic [DW-1:0] rec;
        sig_in = s; evt_ready = r; clr_ovf = c;
`ifdef FEQ_TIMESTAMP_EN
        rec = tb_ts;
`else
        rec = seq_m;
`endif
        pop  = r && (exp_q.size() != 0);
        rise = s && !sig_m;
        sig_m = s;
        if (pop) void'(exp_q.pop_front());
        if (rise) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(rec);
            seq_m = seq_m + 16'd1;
        end
        @(posedge clk); #1;
        if (exp_q.size() != 0) check("head_data", evt_data, exp_q[0]);
    endtask

    initial begin
        rst = 1'b0; sig_in = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;
        sig_m = 1'b1; seq_m = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", evt_valid, 0);
        check("rst_level", evt_level, 0);
        check("rst_data", evt_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        rst = 1'b1;

        // sig_in held high through reset release: no event
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, 0, 0);
        add(0,0,0, 0,0,0,0);
        add(1,0,0, 1,1,0,0);
        add(1,0,0, 1,1,0,0);
        add(0,0,0, 1,1,0,0);
        add(1,0,0, 1,2,0,0);
        add(0,0,0, 1,2,0,0);
        add(1,0,0, 1,3,0,0);
        add(0,0,0, 1,3,0,0);
        add(1,0,0, 1,4,0,0);
        add(0,0,0, 1,4,0,0);
        add(1,0,0, 1,4,1,1);
        add(0,0,0, 1,4,1,1);
        add(1,0,0, 1,4,1,2);
        add(0,1,0, 1,3,1,2);
        add(0,1,0, 1,2,1,2);
        add(0,1,0, 1,1,1,2);
        add(0,1,0, 0,0,1,2);
        add(0,1,0, 0,0,1,2);
        add(1,0,0, 1,1,1,2);
        add(0,0,0, 1,1,1,2);
        add(1,0,0, 1,2,1,2);
        add(0,0,0, 1,2,1,2);
        add(1,0,0, 1,3,1,2);
        add(0,0,0, 1,3,1,2);
        add(1,0,0, 1,4,1,2);
        add(0,0,0, 1,4,1,2);
        add(1,1,0, 1,4,1,2);
        add(0,0,1, 1,4,0,0);
        add(1,0,1, 1,4,1,1);
        add(0,0,0, 1,4,1,1);
        add(0,1,0, 1,3,1,1);
        add(0,1,0, 1,2,1,1);
        add(0,1,0, 1,1,1,1);
        add(0,1,0, 0,0,1,1);

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].r, vecs[i].c);
            check($sformatf("v%0d_valid", i), evt_valid, vecs[i].v);
            check($sformatf("v%0d_level", i), evt_level, vecs[i].lvl);
            check($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
            check($sformatf("v%0d_drop", i), drop_cnt, vecs[i].drp);
        end

        // Fill, clear, then 300 drops: counter saturates
        for (int i = 0; i < DEPTH; i++) begin step(1, 0, 0); step(0, 0, 0); end
        step(0, 0, 1);
        check("clr_ovf", overflow, 0);
        check("clr_drop", drop_cnt, 0);
        for (int i = 0; i < 300; i++) begin step(1, 0, 0); step(0, 0, 0); end
        check("sat_drop", drop_cnt, 255);
        check("sat_ovf", overflow, 1);
        check("sat_level", evt_level, DEPTH);

        // Asynchronous reset with 3 records queued
        step(0, 1, 0);
        check("pre_rst_level", evt_level, 3);
        evt_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_level", evt_level, 0);
        check("arst_valid", evt_valid, 0);
        check("arst_data", evt_data, 0);
        check("arst_ovf", overflow, 0);
        check("arst_drop", drop_cnt, 0);
        exp_q.delete();
        sig_m = 1'b1; seq_m = '0;
        @(posedge clk); #1;
        rst = 1'b1;

        // First event after reset carries a fresh sequence/timestamp
        step(0, 0, 0);
        check("post_rst_idle", evt_level, 0);
        step(1, 0, 0);
        check("post_rst_level", evt_level, 1);
        check("post_rst_valid", evt_valid, 1);
`ifndef FEQ_TIMESTAMP_EN
        check("post_rst_seq0", evt_data, 0);
`endif
        step(1, 1, 0);
        check("post_rst_drain", evt_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
